// File: rtl/fc_layer_link.sv
// fc_layer_link
//   Carries the activation stream from one fc_layer stage into the next one.
//   Each incoming element is clamped to datatype_size bits and written into
//   the downstream input buffer. Once a full vector is buffered and the
//   downstream layer is idle, a one-cycle start pulse is issued. While the
//   downstream layer computes, the upstream producer is held off.
//
// Ports
//   clk, rst        clock, async active-high reset
//   i_valid/i_data  producer element stream (unsigned, in_width bits)
//   o_ready         element accepted this cycle when i_valid is also high
//   o_ibuf_*        registered write port into the next layer's input buffer
//   o_start         one-cycle start pulse to the next layer
//   i_next_busy     busy flag of the next layer
//   o_busy          back-pressure to the previous layer (= !o_ready)
//   o_frame_cnt     vectors handed off and acknowledged (wraps at 16 bits)
//   o_timeout_err   sticky: a start pulse was never acknowledged by busy
module fc_layer_link #(
    parameter int layer_size    = 784,
    parameter int datatype_size = 4,
    parameter int in_width      = 4,
    parameter int arm_timeout   = 16,
    localparam int aw = (layer_size > 1) ? $clog2(layer_size) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [in_width-1:0]      i_data,
    output logic                     o_ready,
    output logic                     o_ibuf_we,
    output logic [aw-1:0]            o_ibuf_addr,
    output logic [datatype_size-1:0] o_ibuf_wr_data,
    output logic                     o_start,
    input  logic                     i_next_busy,
    output logic                     o_busy,
    output logic [15:0]              o_frame_cnt,
    output logic                     o_timeout_err
);
    localparam int tw = (arm_timeout > 1) ? $clog2(arm_timeout) : 1;
    localparam logic [in_width-1:0] dmax = in_width'((2 ** datatype_size) - 1);

    typedef enum logic [1:0] {FILL, START, ARM} state_t;

    state_t                   state, state_n;
    logic [aw-1:0]            count, count_n;
    logic [tw-1:0]            timer, timer_n;
    logic                     start_n, err_n;
    logic [15:0]              frame_n;
    logic                     accept;
    logic [datatype_size-1:0] clamped;

    // Ready drops combinationally with busy so no element slips in while the
    // next layer is reading its buffer.
    assign o_ready = (state == FILL) && !i_next_busy;
    assign o_busy  = !o_ready;
    assign accept  = i_valid && o_ready;

    // Saturate rather than truncate: out-of-range activations become all-ones.
    assign clamped = (i_data > dmax) ? {datatype_size{1'b1}} : i_data[datatype_size-1:0];

    always_comb begin
        state_n = state;
        count_n = count;
        timer_n = timer;
        start_n = 1'b0;
        frame_n = o_frame_cnt;
        err_n   = o_timeout_err;
        case (state)
            FILL: begin
                if (accept) begin
                    if (count == aw'(layer_size - 1)) begin
                        count_n = '0;
                        state_n = START;
                    end else begin
                        count_n = count + aw'(1);
                    end
                end
            end
            // START is only entered the cycle after the last accept, so the
            // final buffer write is already on the bus before o_start rises.
            START: begin
                if (!i_next_busy) begin
                    start_n = 1'b1;
                    timer_n = '0;
                    state_n = ARM;
                end
            end
            ARM: begin
                if (i_next_busy) begin
                    state_n = FILL;
                    frame_n = o_frame_cnt + 16'd1;
                end else if (timer == tw'(arm_timeout - 1)) begin
                    state_n = FILL;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + tw'(1);
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FILL;
            count          <= '0;
            timer          <= '0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_addr    <= '0;
            o_ibuf_wr_data <= '0;
            o_start        <= 1'b0;
            o_frame_cnt    <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            timer         <= timer_n;
            o_start       <= start_n;
            o_frame_cnt   <= frame_n;
            o_timeout_err <= err_n;
            o_ibuf_we     <= accept;
            if (accept) begin
                o_ibuf_addr    <= count;
                o_ibuf_wr_data <= clamped;
            end
        end
    end
endmodule
